decoder_grant_arbiter: RTL and testbench

Round-robin arbiter that shares one 2x4 decoder output port among four requesters. Each cycle the block picks at most one requester, drives the decoder select lines A/B plus enable, and exposes the decoded one-hot grant D[0:3]. A grant is held until the owner releases or drops its request, with an optional hold-time watchdog. Sits between the request sources and the existing 2x4 decoder datapath, replacing hand-driven A/B/enable stimulus.

---
 rtl/decoder_grant_arbiter.sv | 116 +++++++++++
 tb/tb_decoder_grant_arbiter.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/decoder_grant_arbiter.sv
// Round-robin owner of a 2x4 decoder port; grant 1 cycle after req, 1-cycle RECOVER gap after each grant.
// No backpressure: losers wait in place; `define ARB_TIMEOUT_EN adds a HOLD_MAX-cycle grant watchdog.
module decoder_grant_arbiter #(
  parameter int HOLD_MAX = 15,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [0:3] req,
  input  logic       owner_release,  // "release" is a reserved word
  output logic       A,
  output logic       B,
  output logic       enable,
  output logic [0:3] D,
  output logic       busy,
  output logic       timeout
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] RECOVER = 2'd2;

  if (HOLD_MAX < 1 || HOLD_MAX > (2 ** CNT_W) - 1) begin : g_bad_hold_max
    $error("HOLD_MAX does not fit the hold counter width");
  end

  logic [1:0] state;
  logic [1:0] ptr;
  logic [1:0] winner;
  logic [1:0] cand;
  logic       any_req;
  logic       owner_req;
  logic       hold_hit;

  // Walk offsets 4..1 so the smallest offset from ptr overwrites the rest.
  always_comb begin
    winner  = ptr;
    any_req = 1'b0;
    cand    = ptr;
    for (int k = 4; k >= 1; k--) begin
      cand = ptr + 2'(k);
      if (req[cand]) begin
        winner  = cand;
        any_req = 1'b1;
      end
    end
  end

  assign owner_req = req[{A, B}];

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] hold_cnt;

  assign hold_hit = (hold_cnt == CNT_W'(HOLD_MAX - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (state != GRANT) begin
      hold_cnt <= '0;
    end else if (!hold_hit) begin
      hold_cnt <= hold_cnt + CNT_W'(1);
    end
  end
`else
  assign hold_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 2'd3;
      A       <= 1'b0;
      B       <= 1'b0;
      enable  <= 1'b0;
      busy    <= 1'b0;
      timeout <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state  <= GRANT;
            {A, B} <= winner;
            ptr    <= winner;
            enable <= 1'b1;
            busy   <= 1'b1;
          end
        end
        GRANT: begin
          if (owner_release || !owner_req || hold_hit) begin
            state   <= RECOVER;
            enable  <= 1'b0;
            // A voluntary exit on the same edge wins over the watchdog.
            timeout <= hold_hit && !owner_release && owner_req;
          end
        end
        RECOVER: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          enable <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    D           = '0;
    D[{A, B}]   = enable;
  end

endmodule

// File: tb/tb_decoder_grant_arbiter.sv
// Bench for decoder_grant_arbiter: fixed vector table, reset/watchdog sequences, then random traffic vs a model.
module tb_decoder_grant_arbiter;

  localparam int HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [0:3] req = '0;
  logic       rel = 1'b0;
  logic       A, B, enable, busy, timeout;
  logic [0:3] D;

  int n_vec = 0;
  int n_err = 0;

  decoder_grant_arbiter #(.HOLD_MAX(HOLD), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .owner_release(rel),
    .A(A), .B(B), .enable(enable), .D(D), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 granted, 2 recovering; m_held = cycles the owner has held so far.
  int m_phase, m_ptr, m_owner, m_held;
  bit m_to;

  task automatic model_reset();
    m_phase = 0; m_ptr = 3; m_owner = 0; m_held = 0; m_to = 0;
  endtask

  task automatic model_edge(input logic [0:3] r, input logic l);
    bit found;
    int idx;
    m_to  = 0;
    found = 0;
    case (m_phase)
      0: begin
        for (int o = 1; o <= 4; o++) begin
          idx = (m_ptr + o) % 4;
          if (!found && r[idx]) begin
            found = 1; m_owner = idx; m_ptr = idx;
          end
        end
        if (found) begin m_phase = 1; m_held = 1; end
      end
      1: begin
        if (l || !r[m_owner]) m_phase = 2;
`ifdef ARB_TIMEOUT_EN
        else if (m_held == HOLD) begin m_phase = 2; m_to = 1; end
`endif
        else m_held++;
      end
      default: m_phase = 0;
    endcase
  endtask

  task automatic check(input string name, input logic e, input logic [1:0] ab, input logic b, input logic t);
    logic [0:3] d_exp;
    d_exp     = '0;
    d_exp[ab] = e;
    n_vec++;
    if ({A, B, enable, D, busy, timeout} !== {ab, e, d_exp, b, t}) begin
      n_err++;
      $display("FAIL %s: got AB=%b%b en=%b D=%b busy=%b to=%b, want AB=%b en=%b D=%b busy=%b to=%b",
               name, A, B, enable, D, busy, timeout, ab, e, d_exp, b, t);
    end
  endtask

  task automatic check_model(input string name);
    check(name, m_phase == 1, 2'(m_owner), m_phase != 0, m_to);
  endtask

  // Inputs change at the falling edge; outputs are compared at the next falling edge.
  task automatic step(input logic [0:3] r, input logic l);
    req = r; rel = l;
    @(posedge clk);
    model_edge(r, l);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; rel = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [0:3] req;
    logic       rel;
    logic       en;
    logic [1:0] ab;
    logic       busy;
  } vec_t;

  vec_t tbl[29];

  function automatic vec_t mk(input logic [0:3] r, input logic l, input logic e, input logic [1:0] ab, input logic b);
    vec_t v;
    v.req = r; v.rel = l; v.en = e; v.ab = ab; v.busy = b;
    return v;
  endfunction

  initial begin
    int en_cnt, to_cnt;
    logic [0:3] r;

    // Round-robin with all requesting, release pulsed one cycle into each grant.
    tbl[0]  = mk(4'b1111, 0, 1, 2'd0, 1);
    tbl[1]  = mk(4'b1111, 1, 0, 2'd0, 1);
    tbl[2]  = mk(4'b1111, 0, 0, 2'd0, 0);
    tbl[3]  = mk(4'b1111, 0, 1, 2'd1, 1);
    tbl[4]  = mk(4'b1111, 1, 0, 2'd1, 1);
    tbl[5]  = mk(4'b1111, 0, 0, 2'd1, 0);
    tbl[6]  = mk(4'b1111, 0, 1, 2'd2, 1);
    tbl[7]  = mk(4'b1111, 1, 0, 2'd2, 1);
    tbl[8]  = mk(4'b1111, 0, 0, 2'd2, 0);
    tbl[9]  = mk(4'b1111, 1, 1, 2'd3, 1);  // release ignored on the grant edge
    tbl[10] = mk(4'b1111, 1, 0, 2'd3, 1);
    tbl[11] = mk(4'b1111, 0, 0, 2'd3, 0);
    tbl[12] = mk(4'b1111, 0, 1, 2'd0, 1);
    // Owner drops its request.
    tbl[13] = mk(4'b0000, 0, 0, 2'd0, 1);
    tbl[14] = mk(4'b0000, 0, 0, 2'd0, 0);
    // Contenders ignored while idx 1 holds, then idx 3 wins.
    tbl[15] = mk(4'b0110, 0, 1, 2'd1, 1);
    tbl[16] = mk(4'b1111, 0, 1, 2'd1, 1);
    tbl[17] = mk(4'b1101, 0, 1, 2'd1, 1);
    tbl[18] = mk(4'b1101, 1, 0, 2'd1, 1);
    tbl[19] = mk(4'b1001, 0, 0, 2'd1, 0);
    tbl[20] = mk(4'b1001, 0, 1, 2'd3, 1);
    tbl[21] = mk(4'b1001, 1, 0, 2'd3, 1);
    tbl[22] = mk(4'b1001, 0, 0, 2'd3, 0);
    // Wrap 3 -> 0, then from ptr 0 the next is 3.
    tbl[23] = mk(4'b1001, 0, 1, 2'd0, 1);
    tbl[24] = mk(4'b1001, 1, 0, 2'd0, 1);
    tbl[25] = mk(4'b1001, 0, 0, 2'd0, 0);
    tbl[26] = mk(4'b1001, 0, 1, 2'd3, 1);
    tbl[27] = mk(4'b0000, 1, 0, 2'd3, 1);
    tbl[28] = mk(4'b0000, 0, 0, 2'd3, 0);

    model_reset();
    repeat (2) @(negedge clk);
    check("reset_state", 0, 2'd0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 29; i++) begin
      step(tbl[i].req, tbl[i].rel);
      check($sformatf("table[%0d]", i), tbl[i].en, tbl[i].ab, tbl[i].busy, 1'b0);
    end

    // Asynchronous reset in the middle of a grant.
    step(4'b0100, 0);
    check("grant_before_reset", 1, 2'd1, 1, 0);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check("reset_mid_grant", 0, 2'd0, 0, 0);
    @(negedge clk);
    check("reset_held", 0, 2'd0, 0, 0);
    rst_n = 1'b1;
    step(4'b0100, 0);
    check("grant_after_reset", 1, 2'd1, 1, 0);

    // Watchdog: idx 0 holds forever while idx 1 waits.
    do_reset();
    en_cnt = 0; to_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      step(4'b1100, 0);
      check_model($sformatf("watchdog[%0d]", i));
      en_cnt += int'(enable);
      to_cnt += int'(timeout);
    end
    n_vec++;
`ifdef ARB_TIMEOUT_EN
    if (en_cnt != 6 || to_cnt != 1) begin
      n_err++;
      $display("FAIL watchdog_totals: got en_cycles=%0d timeouts=%0d, want 6 and 1", en_cnt, to_cnt);
    end
`else
    if (en_cnt != 8 || to_cnt != 0) begin
      n_err++;
      $display("FAIL watchdog_totals: got en_cycles=%0d timeouts=%0d, want 8 and 0", en_cnt, to_cnt);
    end
`endif

    // Random traffic; requests tend to stay stable so long holds occur.
    do_reset();
    r = '0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      step(r, $urandom_range(0, 5) == 0);
      check_model($sformatf("random[%0d]", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
